writeback_queue: RTL

Buffers results from the ALU and the load path and drains them, one per cycle, into the single write port of the 32x32 register file. Sits between the execute/memory stages and the register file write port (i_writeAdd/i_writeData/write enable). Drops writes to register 0, which is hardwired to zero, and optionally forwards queued-but-unwritten values to the read ports.

---
 rtl/writeback_queue_pkg.sv | 17 +
 rtl/writeback_queue_if.sv | 56 +++++
 rtl/writeback_queue_lookup.sv | 38 +++
 rtl/writeback_queue.sv | 132 +++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Provides the {addr, data} entry record, default bus widths and the
// hardwired-zero register index.
package wbq_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Register 0 reads as zero, so writes to it are swallowed at the input.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage : wbq_pkg

// File: rtl/writeback_queue_if.sv
// Bundle of the producer handshakes, register-file write port and forward
// lookup ports of the writeback queue.
// slave modport: queue side. master modport: producer/register-file side.
interface writeback_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    // load result path
    logic              i_memValid;
    logic [ADDR_W-1:0] i_memAdd;
    logic [DATA_W-1:0] i_memData;
    logic              o_memReady;
    // ALU result path
    logic              i_aluValid;
    logic [ADDR_W-1:0] i_aluAdd;
    logic [DATA_W-1:0] i_aluData;
    logic              o_aluReady;
    // register file write port
    logic              i_writeStall;
    logic              o_writeEn;
    logic [ADDR_W-1:0] o_writeAdd;
    logic [DATA_W-1:0] o_writeData;
    // forward lookup
    logic [ADDR_W-1:0] i_readAdd1;
    logic [ADDR_W-1:0] i_readAdd2;
    logic              o_fwdHit1;
    logic              o_fwdHit2;
    logic [DATA_W-1:0] o_fwdData1;
    logic [DATA_W-1:0] o_fwdData2;
    // occupancy
    logic [CNT_W-1:0]  o_count;
    logic              o_empty;
    logic              o_full;

    modport slave (
        input  i_memValid, i_memAdd, i_memData,
        input  i_aluValid, i_aluAdd, i_aluData,
        input  i_writeStall, i_readAdd1, i_readAdd2,
        output o_memReady, o_aluReady,
        output o_writeEn, o_writeAdd, o_writeData,
        output o_fwdHit1, o_fwdHit2, o_fwdData1, o_fwdData2,
        output o_count, o_empty, o_full
    );

    modport master (
        output i_memValid, i_memAdd, i_memData,
        output i_aluValid, i_aluAdd, i_aluData,
        output i_writeStall, i_readAdd1, i_readAdd2,
        input  o_memReady, o_aluReady,
        input  o_writeEn, o_writeAdd, o_writeData,
        input  o_fwdHit1, o_fwdHit2, o_fwdData1, o_fwdData2,
        input  o_count, o_empty, o_full
    );

endinterface : writeback_queue_if

// File: rtl/writeback_queue_lookup.sv
// Newest-match search of queued writes for one register read address.
// Latency: purely combinational. Backpressure: none (read-only view).
// Ports: entries/head/count describe the live queue; addr in; hit/data out.
module wbq_lookup
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  entry_t            entries [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest (head) to newest; a later match overwrites an earlier
    // one so the value closest to the tail wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entries[idx].addr == addr) && (addr != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule : wbq_lookup

// File: rtl/writeback_queue.sv
// Queues load/ALU results and drains one per cycle into the register file write port.
// Latency: entry accepted at edge N is presented with o_writeEn in the following cycle.
// Backpressure: readies from registered free space only (pop does not free space); load wins the last slot.
// Ports: i_clk, i_rst (async, active-high) plus bus (writeback_queue_if.slave).
// Optional forwarding lookup is built when WBQ_FORWARD_EN is defined; otherwise fwd outputs are 0.
module writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    writeback_queue_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    cnt_t   count_q, count_d;
    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    cnt_t   free;
    logic   mem_rdy, alu_rdy;
    logic   mem_acc, alu_acc;
    logic   mem_store, alu_store;
    logic   pop;
    ptr_t   alu_slot;

    always_comb begin
        free = cnt_t'(DEPTH) - count_q;

        mem_rdy = (free >= cnt_t'(1));
        // The ALU only gets the last free slot when the load path is idle.
        alu_rdy = (free >= cnt_t'(2)) || ((free == cnt_t'(1)) && !bus.i_memValid);

        mem_acc = bus.i_memValid && mem_rdy;
        alu_acc = bus.i_aluValid && alu_rdy;

        // Writes to r0 complete the handshake but are never stored.
        mem_store = mem_acc && (bus.i_memAdd != REG_ZERO);
        alu_store = alu_acc && (bus.i_aluAdd != REG_ZERO);

        pop = (count_q != '0) && !bus.i_writeStall;

        // Load is older, so it takes the tail slot and the ALU result follows it.
        alu_slot = mem_store ? (tail_q + ptr_t'(1)) : tail_q;

        mem_d = mem_q;
        if (mem_store) begin
            mem_d[tail_q] = '{addr: bus.i_memAdd, data: bus.i_memData};
        end
        if (alu_store) begin
            mem_d[alu_slot] = '{addr: bus.i_aluAdd, data: bus.i_aluData};
        end

        tail_d  = tail_q + ptr_t'(mem_store) + ptr_t'(alu_store);
        head_d  = pop ? (head_q + ptr_t'(1)) : head_q;
        count_d = count_q + cnt_t'(mem_store) + cnt_t'(alu_store) - cnt_t'(pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by head/count.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign bus.o_memReady  = mem_rdy;
    assign bus.o_aluReady  = alu_rdy;
    assign bus.o_writeEn   = pop;
    assign bus.o_writeAdd  = mem_q[head_q].addr;
    assign bus.o_writeData = mem_q[head_q].data;
    assign bus.o_count     = count_q;
    assign bus.o_empty     = (count_q == '0);
    assign bus.o_full      = (count_q == cnt_t'(DEPTH));

`ifdef WBQ_FORWARD_EN
    // Lookup sees registered entries only: same-cycle enqueues are invisible,
    // while the head entry being written this cycle is still counted.
    wbq_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lookup1 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (bus.i_readAdd1),
        .hit     (bus.o_fwdHit1),
        .data    (bus.o_fwdData1)
    );

    wbq_lookup #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lookup2 (
        .entries (mem_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (bus.i_readAdd2),
        .hit     (bus.o_fwdHit2),
        .data    (bus.o_fwdData2)
    );
`else
    logic unused_rd;
    assign unused_rd      = ^{bus.i_readAdd1, bus.i_readAdd2};
    assign bus.o_fwdHit1  = 1'b0;
    assign bus.o_fwdHit2  = 1'b0;
    assign bus.o_fwdData1 = '0;
    assign bus.o_fwdData2 = '0;
`endif

endmodule : writeback_queue
